// File: rtl/mux_nx1_stream_if.sv
// mux_nx1_stream_if
// Bundles the channel-side and consumer-side signals of the N:1 stream mux.
//   N, W, CW : channel count, word width, transfer-counter width
//   mode, sel             : channel selection controls (driven by the master)
//   in_data/in_valid      : N producer channels, channel i at [i*W +: W]
//   in_ready              : per-channel accept strobe (driven by the mux)
//   out_data/out_valid    : registered output word (driven by the mux)
//   out_ready             : consumer back-pressure (driven by the master)
//   out_ch, xfer_cnt      : source channel of the held word, accepted-word count
// The slave modport is the mux view; the master modport is the environment view.
interface mux_nx1_stream_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CW = 16
);
  localparam int SW = $clog2(N);

  logic            mode;
  logic [SW-1:0]   sel;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_ch;
  logic [CW-1:0]   xfer_cnt;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ch, xfer_cnt
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch, xfer_cnt
  );
endinterface

// File: rtl/mux_nx1_stream.sv
// mux_nx1_stream
// N-input, W-bit registered stream multiplexer with valid/ready handshakes.
// One channel is granted per cycle, either by explicit select (mode=0) or by
// round-robin arbitration (mode=1), and the winning word is captured into a
// single output register.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux_nx1_stream_if slave view (mode, sel, in_*, out_*, out_ch,
//           xfer_cnt)
module mux_nx1_stream #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_nx1_stream_if.slave bus
);
  localparam int SW = $clog2(N);

  logic [W-1:0]  data_p1;
  logic [SW-1:0] ch_p1;
  logic          vld_p1;
  logic [CW-1:0] cnt_p1;
  logic [SW-1:0] ptr;

  logic          load_en;
  logic          sel_vld;
  logic          rr_vld;
  logic [SW-1:0] rr_idx;
  logic          grant_vld;
  logic [SW-1:0] grant_idx;
  logic [W-1:0]  word;
  logic [N-1:0]  ready;
  logic          xfer;

  // Pointer advance with explicit wrap so non-power-of-2 N returns to 0.
  function automatic logic [SW-1:0] next_ptr(input logic [SW-1:0] k);
    if (k == SW'(N - 1)) return '0;
    return k + SW'(1);
  endfunction

  // ---- stage p0: grant selection (combinational) ----
  assign load_en = ~vld_p1 | bus.out_ready;

  always_comb begin
    sel_vld = 1'b0;
    // Out-of-range select yields no grant.
    if (int'(bus.sel) < N) sel_vld = bus.in_valid[bus.sel];
  end

  always_comb begin
    int c;
    rr_vld = 1'b0;
    rr_idx = '0;
    c      = 0;
    for (int i = 0; i < N; i++) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (!rr_vld && bus.in_valid[c]) begin
        rr_vld = 1'b1;
        rr_idx = SW'(c);
      end
    end
  end

  assign grant_vld = bus.mode ? rr_vld : sel_vld;
  assign grant_idx = bus.mode ? rr_idx : bus.sel;

  always_comb begin
    word = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SW'(i)) word = bus.in_data[i*W +: W];
    end
  end

  // rst_n gating keeps in_ready low while reset is held, even though the
  // empty output stage would otherwise be willing to load.
  always_comb begin
    ready = '0;
    for (int i = 0; i < N; i++) begin
      ready[i] = rst_n & load_en & grant_vld & (grant_idx == SW'(i));
    end
  end

  assign xfer         = rst_n & load_en & grant_vld;
  assign bus.in_ready = ready;

  // ---- stage p1: output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
      cnt_p1  <= '0;
      ptr     <= '0;
    end else if (load_en) begin
      vld_p1 <= xfer;
      if (xfer) begin
        data_p1 <= word;
        ch_p1   <= grant_idx;
        cnt_p1  <= cnt_p1 + CW'(1);
        if (bus.mode) ptr <= next_ptr(grant_idx);
      end
    end
  end

  assign bus.out_data  = data_p1;
  assign bus.out_valid = vld_p1;
  assign bus.out_ch    = ch_p1;
  assign bus.xfer_cnt  = cnt_p1;
endmodule

// File: tb/tb_mux_nx1_stream.sv
module tb_mux_nx1_stream;
  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Main instance: N=4, W=8, CW=16.
  mux_nx1_stream_if #(.N(4), .W(8), .CW(16)) a ();
  mux_nx1_stream #(.N(4), .W(8), .CW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a)
  );

  // Secondary instance: N=3 (non-power-of-2 wrap), CW=4 (counter wrap).
  mux_nx1_stream_if #(.N(3), .W(8), .CW(4)) b ();
  mux_nx1_stream #(.N(3), .W(8), .CW(4)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_ch[6];
    exp_ch = '{0, 1, 3, 0, 1, 3};

    rst_n       = 1'b0;
    a.mode      = 1'b0;
    a.sel       = 2'd0;
    a.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    a.in_valid  = 4'b1111;
    a.out_ready = 1'b1;
    b.mode      = 1'b1;
    b.sel       = 2'd0;
    b.in_data   = {8'hC2, 8'hC1, 8'hC0};
    b.in_valid  = 3'b111;
    b.out_ready = 1'b1;

    // Reset held with all channels valid
    step();
    step();
    chk("rst_out_valid", 32'(a.out_valid), 32'd0);
    chk("rst_out_data",  32'(a.out_data),  32'd0);
    chk("rst_xfer_cnt",  32'(a.xfer_cnt),  32'd0);
    chk("rst_in_ready",  32'(a.in_ready),  32'd0);
    chk("rst_in_ready3", 32'(b.in_ready),  32'd0);
    chk("rst_out_valid3", 32'(b.out_valid), 32'd0);

    // Park the N=3 instance until the end
    b.in_valid = 3'b000;
    rst_n      = 1'b1;

    // Select mode, sel=2
    a.sel = 2'd2;
    #1;
    chk("sel2_in_ready", 32'(a.in_ready), 32'b0100);
    step();
    chk("sel2_valid_c1", 32'(a.out_valid), 32'd1);
    chk("sel2_data_c1",  32'(a.out_data),  32'hA2);
    chk("sel2_ch_c1",    32'(a.out_ch),    32'd2);
    chk("sel2_cnt_c1",   32'(a.xfer_cnt),  32'd1);
    step();
    chk("sel2_data_c2",  32'(a.out_data),  32'hA2);
    chk("sel2_cnt_c2",   32'(a.xfer_cnt),  32'd2);
    step();
    chk("sel2_cnt_c3",   32'(a.xfer_cnt),  32'd3);

    // sel=3 with channel 3 not valid: no grant
    a.sel      = 2'd3;
    a.in_valid = 4'b0111;
    #1;
    chk("sel3_in_ready", 32'(a.in_ready), 32'd0);
    chk("sel3_valid_pre", 32'(a.out_valid), 32'd1);
    step();
    chk("sel3_valid_drop", 32'(a.out_valid), 32'd0);
    chk("sel3_data_hold",  32'(a.out_data),  32'hA2);
    chk("sel3_cnt_hold",   32'(a.xfer_cnt),  32'd3);

    // Round-robin over channels 0,1,3 (ptr still 0 after select mode)
    a.mode     = 1'b1;
    a.in_valid = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_valid", 32'(a.out_valid), 32'd1);
      chk("rr_ch",    32'(a.out_ch),    32'(exp_ch[i]));
      chk("rr_data",  32'(a.out_data),  32'(8'hA0 + exp_ch[i]));
    end
    chk("rr_cnt", 32'(a.xfer_cnt), 32'd9);

    // Back-pressure with 0x55 held
    a.mode      = 1'b0;
    a.sel       = 2'd1;
    a.in_valid  = 4'b0010;
    a.in_data   = {8'hA3, 8'hA2, 8'h55, 8'hA0};
    step();
    chk("bp_load_data", 32'(a.out_data), 32'h55);
    chk("bp_load_cnt",  32'(a.xfer_cnt), 32'd10);
    a.out_ready = 1'b0;
    a.in_data   = {8'hA3, 8'hA2, 8'h66, 8'hA0};
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(a.in_ready), 32'd0);
      step();
      chk("bp_data",  32'(a.out_data),  32'h55);
      chk("bp_ch",    32'(a.out_ch),    32'd1);
      chk("bp_valid", 32'(a.out_valid), 32'd1);
      chk("bp_cnt",   32'(a.xfer_cnt),  32'd10);
    end
    a.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(a.in_ready), 32'b0010);
    step();
    chk("bp_next_data",  32'(a.out_data),  32'h66);
    chk("bp_next_valid", 32'(a.out_valid), 32'd1);
    chk("bp_next_cnt",   32'(a.xfer_cnt),  32'd11);

    // Advance ptr, then reset mid-operation
    a.in_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    a.mode     = 1'b1;
    a.in_valid = 4'b1111;
    step();
    chk("pre_rst_ch0", 32'(a.out_ch), 32'd0);
    step();
    chk("pre_rst_ch1", 32'(a.out_ch), 32'd1);
    chk("pre_rst_cnt", 32'(a.xfer_cnt), 32'd13);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",    32'(a.out_valid), 32'd0);
    chk("mid_rst_data",     32'(a.out_data),  32'd0);
    chk("mid_rst_cnt",      32'(a.xfer_cnt),  32'd0);
    chk("mid_rst_in_ready", 32'(a.in_ready),  32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", 32'(a.out_valid), 32'd1);
    chk("post_rst_ch",    32'(a.out_ch),    32'd0);
    chk("post_rst_data",  32'(a.out_data),  32'hA0);
    chk("post_rst_cnt",   32'(a.xfer_cnt),  32'd1);

    // N=3 round-robin wrap 2->0 and CW=4 counter wrap after 17 transfers
    b.in_valid = 3'b111;
    for (int i = 0; i < 17; i++) begin
      step();
      chk("n3_ch",   32'(b.out_ch),   32'(i % 3));
      chk("n3_data", 32'(b.out_data), 32'(8'hC0 + (i % 3)));
    end
    chk("n3_cnt_wrap", 32'(b.xfer_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_nx1_stream.md
# mux_nx1_stream

Parametrised N-input, W-bit registered stream multiplexer with valid/ready handshakes. It is the next generation of the team's 2:1 dataflow mux. It selects one of N input channels, either by an explicit select or by round-robin arbitration, and registers the winning word into a single output stage. It sits between multiple producers and one consumer wherever channel merging with back-pressure is needed.

## Interface
Parameters:
- N, 4, number of input channels (N >= 2)
- W, 8, data width per channel
- CW, 16, width of transfer counter
- SW, derived, $clog2(N); not to be overridden

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- mode  input  1  0 = select-driven, 1 = round-robin
- sel  input  SW  channel index used when mode=0
- in_data  input  N*W  channel i occupies bits [i*W +: W]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready
- out_data  output  W  registered output word
- out_valid  output  1  output word valid
- out_ready  input  1  consumer ready
- out_ch  output  SW  channel index of the current output word
- xfer_cnt  output  CW  count of accepted input transfers

## Operation
- load_en = ~out_valid | out_ready. The output stage accepts a new word only when load_en=1.
- Grant, mode=0:
  - grant_idx = sel.
  - grant_vld = (sel < N) & in_valid[sel].
  - If sel >= N, there is no grant.
- Grant, mode=1:
  - Search channels ptr, ptr+1, …, wrapping mod N.
  - The first channel with in_valid=1 wins.
  - If no channel is valid, grant_vld=0.
- in_ready[i] = load_en & grant_vld & (grant_idx == i). At most one bit is set. A combinational in_valid->in_ready path is permitted.
- A transfer on channel k occurs when in_valid[k] & in_ready[k]. On the next edge:
  - out_data <= in_data[k]
  - out_ch <= k
  - out_valid <= 1
  - xfer_cnt <= xfer_cnt + 1, wrapping at 2^CW
- If load_en=1 and no transfer occurs: out_valid <= 0; out_data and out_ch hold their last values.
- If load_en=0: out_data, out_ch and out_valid hold unchanged.
- Round-robin pointer ptr (SW bits, internal):
  - After a transfer on channel k while mode=1: ptr <= (k+1) mod N. The wrap from N-1 goes to 0, including non-power-of-2 N.
  - While mode=0, ptr holds.
- mode and sel are sampled combinationally each cycle. Changing either never disturbs a word already held in the output register.
- Asynchronous reset, rst_n=0:
  - out_valid=0, out_data=0, out_ch=0
  - ptr=0, xfer_cnt=0
  - in_ready=0, since out_valid=0 but gating follows grant; in_ready reads all-zero while rst_n is low.
- Reset asserted mid-transfer discards the held word. No output transfer is reported.

## Timing
- Latency: input accept edge -> out_valid=1 after that same edge (1 cycle).
- Throughput: 1 word per cycle while out_ready=1 and a grant exists.
- Back-pressure: while out_valid=1 & out_ready=0:
  - out_data and out_ch remain stable.
  - All in_ready bits are 0.
- Simultaneous output drain and input accept in the same cycle is supported (load_en=1). No bubble is inserted.
- Reset deassertion is synchronous to clk by system convention. The first transfer is possible on the first edge with rst_n=1.

## Test plan
- Reset:
  - Stimulus: hold rst_n=0 with all in_valid=1.
  - Required response: out_valid=0, out_data=0, xfer_cnt=0, in_ready=0000. After release with out_ready=1, the first word arrives 1 cycle later.
- Select mode:
  - Stimulus: mode=0, sel=2, in_valid=1111, data i = 0xA0+i, out_ready=1.
  - Required response: in_ready=0100; out_data=0xA2 and out_ch=2 every cycle; xfer_cnt increments by 1 per cycle.
  - Stimulus: set sel=3 and in_valid[3]=0.
  - Required response: in_ready=0000, and out_valid drops after one edge.
- Round-robin:
  - Stimulus: mode=1, in_valid=1011, out_ready=1.
  - Required response: out_ch sequence 0,1,3,0,1,3. Channel 2 is never granted.
  - Stimulus: N=3 build.
  - Required response: ptr wraps 2->0.
- Back-pressure:
  - Stimulus: while out_valid=1 (out_data=0x55), hold out_ready=0 for 3 cycles.
  - Required response: out_data=0x55 stable, in_ready=0000, xfer_cnt frozen. On out_ready=1 the drain and next accept happen in the same cycle.
- Counter wrap and reset mid-operation:
  - Stimulus: CW=4, 17 transfers.
  - Required response: xfer_cnt=1.
  - Stimulus: assert rst_n=0 while out_valid=1.
  - Required response: out_valid=0 immediately (asynchronous); ptr=0 afterwards, so the next round-robin grant starts at channel 0.
